// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer built as a registered tree of 2:1 stages, with
// valid/ready handshake and an optional self-stepping scan mode.
module mux_tree_pipe #(
    parameter int N_IN = 13,
    parameter int W    = 8,
    parameter int SW   = $clog2(N_IN),
    parameter int L    = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN*W-1:0] in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    logic                  advance;
    logic                  launch;
    logic [SW-1:0]         scan_ch;
    logic [SW-1:0]         eff_sel;
    logic                  eff_err;
    logic [(2**L)*W-1:0]   leaves;

    // Whole pipeline moves in lockstep; bubbles are kept, not squeezed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign launch   = in_valid && advance;

    assign eff_sel = mode ? scan_ch : in_sel;
    assign eff_err = !mode && (32'(eff_sel) >= N_IN);

    always_comb begin
        leaves = '0;
        leaves[N_IN*W-1:0] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch <= '0;
        end else if (launch && mode) begin
            if (scan_ch == SW'(N_IN - 1)) begin
                scan_ch <= '0;
            end else begin
                scan_ch <= scan_ch + 1'b1;
            end
        end
    end

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int NN = 2 ** (L - j);

        logic [2*NN*W-1:0] src;
        logic              sbit;
        logic [SW-1:0]     ch_src;
        logic              err_src;
        logic              vld_src;
        logic [NN*W-1:0]   d_d;
        logic [NN*W-1:0]   d_q;
        logic [SW-1:0]     ch_q;
        logic              err_q;
        logic              vld_q;

        if (j == 1) begin : g_head
            assign src     = leaves;
            assign sbit    = eff_sel[0];
            assign ch_src  = eff_sel;
            assign err_src = eff_err;
            assign vld_src = launch;
        end else begin : g_tail
            // The full select travels as the channel index; level j uses bit j-1.
            assign src     = g_lvl[j-1].d_q;
            assign sbit    = g_lvl[j-1].ch_q[j-1];
            assign ch_src  = g_lvl[j-1].ch_q;
            assign err_src = g_lvl[j-1].err_q;
            assign vld_src = g_lvl[j-1].vld_q;
        end

        always_comb begin
            d_d = '0;
            for (int i = 0; i < NN; i++) begin
                d_d[i*W +: W] = sbit ? src[(2*i+1)*W +: W] : src[(2*i)*W +: W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q   <= '0;
                ch_q  <= '0;
                err_q <= 1'b0;
                vld_q <= 1'b0;
            end else if (advance) begin
                d_q   <= d_d;
                ch_q  <= ch_src;
                err_q <= err_src;
                vld_q <= vld_src;
            end
        end
    end

    assign out_data  = g_lvl[L].d_q;
    assign out_ch    = g_lvl[L].ch_q;
    assign out_err   = g_lvl[L].err_q;
    assign out_valid = g_lvl[L].vld_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: default 13x8 instance plus a 2x1 minimum instance.
module tb_mux_tree_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [103:0] in_data;
    logic [3:0]   in_sel;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    logic         m_in_valid;
    logic         m_in_ready;
    logic [1:0]   m_in_data;
    logic         m_in_sel;
    logic         m_out_data;
    logic         m_out_ch;
    logic         m_out_err;
    logic         m_out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.N_IN(13), .W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_tree_pipe #(.N_IN(2), .W(1)) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (m_in_data),
        .in_sel    (m_in_sel),
        .mode      (1'b0),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .out_data  (m_out_data),
        .out_ch    (m_out_ch),
        .out_err   (m_out_err),
        .out_valid (m_out_valid),
        .out_ready (1'b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ch, input int data, input int err);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(data));
        chk({tag, "_err"},   32'(out_err),   32'(err));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = '0;
        mode       = 1'b0;
        out_ready  = 1'b1;
        m_in_valid = 1'b0;
        m_in_sel   = 1'b0;
        m_in_data  = 2'b10;
        for (int k = 0; k < 13; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_min_valid", 32'(m_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct sweep 0..12, back-to-back
        for (int e = 0; e < 16; e++) begin
            in_valid = (e < 13);
            in_sel   = 4'(e);
            tick();
            if (e < 3) chk("sweep_idle", 32'(out_valid), 0);
            else chk_out("sweep", e - 3, 8'h10 + e - 3, 0);
        end

        // Out-of-range selects 13 and 15
        for (int e = 0; e < 5; e++) begin
            in_valid = (e < 2);
            in_sel   = (e == 0) ? 4'd13 : 4'd15;
            tick();
            if (e < 3) chk("oor_idle", 32'(out_valid), 0);
            else if (e == 3) chk_out("oor13", 13, 0, 1);
            else chk_out("oor15", 15, 0, 1);
        end
        in_valid = 1'b0;

        // Backpressure: 5 words, 3 stalled cycles
        for (int e = 0; e < 4; e++) begin
            in_valid = 1'b1;
            in_sel   = 4'(e);
            tick();
        end
        chk_out("bp_w0", 0, 8'h10, 0);
        out_ready = 1'b0;
        in_sel    = 4'd4;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        repeat (3) begin
            tick();
            chk_out("bp_stall", 0, 8'h10, 0);
            chk("bp_stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            chk_out("bp_drain", k, 8'h10 + k, 0);
            tick();
        end
        chk("bp_empty", 32'(out_valid), 0);

        // Scan mode: 15 launches, in_sel ignored
        mode = 1'b1;
        for (int e = 0; e < 18; e++) begin
            in_valid = (e < 15);
            in_sel   = 4'($urandom);
            tick();
            if (e < 3) chk("scan_idle", 32'(out_valid), 0);
            else chk_out("scan", (e - 3) % 13, 8'h10 + (e - 3) % 13, 0);
        end

        // Mode toggle keeps the scan counter (now at 2)
        mode     = 1'b0;
        in_sel   = 4'd7;
        in_valid = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk_out("toggle_direct", 7, 8'h17, 0);
        tick();
        chk_out("toggle_scan", 2, 8'h12, 0);

        // Async reset with words in flight
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_ch", 32'(out_ch), 0);
        chk("midrst_err", 32'(out_err), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            chk("postrst_no_stale", 32'(out_valid), 0);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk_out("postrst_scan0", 0, 8'h10, 0);

        // Minimum configuration: one stage, sel alternates
        for (int e = 0; e < 4; e++) begin
            m_in_valid = 1'b1;
            m_in_sel   = 1'(e % 2);
            tick();
            chk("min_valid", 32'(m_out_valid), 1);
            chk("min_data", 32'(m_out_data), 32'(e % 2));
            chk("min_ch", 32'(m_out_ch), 32'(e % 2));
            chk("min_err", 32'(m_out_err), 0);
        end
        m_in_valid = 1'b0;
        tick();
        chk("min_empty", 32'(m_out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
